// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: a sign position followed by BCD digits.
// Frame data is latched into shadows at each frame wrap so a frame never tears.
module seg_scan_driver #(
  parameter int DIGITS     = 6,
  parameter int SCAN_DIV   = 8192,
  parameter int ACTIVE_LOW = 1,
  localparam int W     = 4 * (DIGITS - 1) + 1,
  localparam int SEL_W = $clog2(DIGITS),
  localparam int CNT_W = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     adata,
  input  logic [W-1:0]     bdata,
  input  logic [DIGITS-1:0] dp,
  input  logic             blank_lz,
  output logic [SEL_W-1:0] sel,
  output logic [7:0]       seg,
  output logic             frame_done
);

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [W-1:0]      shadow_reg, shadow_next;
  logic [DIGITS-1:0] dp_shadow_reg, dp_shadow_next;
  logic              frame_done_reg;
  logic [7:0]        seg_reg, seg_next;
  logic              tick, wrap;
  logic [W-1:0]      src;
  logic [7:0]        code [DIGITS];

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] n);
    case (n)
      4'd0:    bcd_to_seg = 8'hC0;
      4'd1:    bcd_to_seg = 8'hF9;
      4'd2:    bcd_to_seg = 8'hA4;
      4'd3:    bcd_to_seg = 8'hB0;
      4'd4:    bcd_to_seg = 8'h99;
      4'd5:    bcd_to_seg = 8'h92;
      4'd6:    bcd_to_seg = 8'h82;
      4'd7:    bcd_to_seg = 8'hF8;
      4'd8:    bcd_to_seg = 8'h80;
      4'd9:    bcd_to_seg = 8'h90;
      default: bcd_to_seg = 8'hFF;
    endcase
  endfunction

  assign tick = (cnt_reg == CNT_W'(SCAN_DIV - 1));
  assign wrap = tick && (sel_reg == SEL_W'(DIGITS - 1));
  assign src  = (bdata != '0) ? bdata : adata;

  always_comb begin
    cnt_next       = tick ? '0 : cnt_reg + CNT_W'(1);
    sel_next       = sel_reg;
    if (tick) sel_next = wrap ? '0 : sel_reg + SEL_W'(1);
    shadow_next    = wrap ? src : shadow_reg;
    dp_shadow_next = wrap ? dp : dp_shadow_reg;
  end

  // Codes are built from the next-state shadows so seg follows sel on the same edge.
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    logic [7:0] base;
    lead = 1'b1;
    nib  = '0;
    base = '0;
    for (int p = 0; p < DIGITS; p++) begin
      if (p == 0) begin
        base = shadow_next[W-1] ? 8'hBF : 8'hFF;
      end else begin
        nib  = shadow_next[4*(DIGITS-1-p) +: 4];
        lead = lead && (nib == 4'd0);
        base = (blank_lz && lead && (p != DIGITS - 1)) ? 8'hFF : bcd_to_seg(nib);
      end
      code[p] = {base[7] & ~dp_shadow_next[p], base[6:0]};
    end
  end

  always_comb begin
    seg_next = code[sel_next];
    if (ACTIVE_LOW == 0) seg_next = ~seg_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      sel_reg        <= '0;
      shadow_reg     <= '0;
      dp_shadow_reg  <= '0;
      frame_done_reg <= 1'b0;
      seg_reg        <= (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    end else begin
      cnt_reg        <= cnt_next;
      sel_reg        <= sel_next;
      shadow_reg     <= shadow_next;
      dp_shadow_reg  <= dp_shadow_next;
      frame_done_reg <= wrap;
      seg_reg        <= seg_next;
    end
  end

  assign sel        = sel_reg;
  assign seg        = seg_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=6, SCAN_DIV=4, ACTIVE_LOW=1.
module tb_seg_scan_driver;
  localparam int DIGITS = 6;
  localparam int W      = 21;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [W-1:0] adata = '0;
  logic [W-1:0] bdata = '0;
  logic [DIGITS-1:0] dp = '0;
  logic        blank_lz = 1'b0;
  logic [2:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fr_seg [DIGITS];
  logic [2:0] fr_sel [DIGITS];
  int         fr_fd_cnt;
  logic       fr_fd_next;

  seg_scan_driver #(.DIGITS(6), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .adata(adata), .bdata(bdata), .dp(dp),
    .blank_lz(blank_lz), .sel(sel), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for a fresh frame_done pulse, then records one full frame (24 cycles).
  task automatic capture_frame(input string tag);
    int guard;
    guard = 0;
    do begin
      step(1);
      guard++;
    end while (!frame_done && guard < 100);
    if (!frame_done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s frame_timeout: frame_done never seen, required a pulse within 100 cycles", tag);
    end
    fr_fd_cnt = 0;
    for (int i = 0; i < 4 * DIGITS; i++) begin
      if (i % 4 == 0) begin
        fr_sel[i/4] = sel;
        fr_seg[i/4] = seg;
      end
      if (frame_done) fr_fd_cnt++;
      step(1);
    end
    fr_fd_next = frame_done;
    $display("%s frame: %h %h %h %h %h %h", tag,
             fr_seg[0], fr_seg[1], fr_seg[2], fr_seg[3], fr_seg[4], fr_seg[5]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      vectors++;
      if (sel !== 3'd0 || seg !== 8'hFF || frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: sel=%0d seg=%h fd=%b, required sel=0 seg=ff fd=0", sel, seg, frame_done);
      end
    end
    rst = 1'b0;
    step(3);
    vectors++;
    if (sel !== 3'd0 || seg !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_release3: sel=%0d seg=%h, required sel=0 seg=ff", sel, seg);
    end
    step(1);
    vectors++;
    if (sel !== 3'd1 || seg !== 8'hC0) begin
      miscompares++;
      $display("FAIL reset_release4: sel=%0d seg=%h, required sel=1 seg=c0", sel, seg);
    end
    $display("reset: sel=%0d seg=%h after 4 edges", sel, seg);
  endtask

  task automatic test_priority();
    logic [7:0] exp [DIGITS] = '{8'hBF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    adata = {1'b1, 20'h12345};
    bdata = '0;
    blank_lz = 1'b0;
    dp = '0;
    capture_frame("priority");
    for (int p = 0; p < DIGITS; p++) begin
      vectors++;
      if (fr_seg[p] !== exp[p] || fr_sel[p] !== 3'(p)) begin
        miscompares++;
        $display("FAIL priority_pos%0d: sel=%0d seg=%h, required sel=%0d seg=%h", p, fr_sel[p], fr_seg[p], p, exp[p]);
      end
    end
    vectors++;
    if (fr_fd_cnt != 1 || fr_fd_next !== 1'b1) begin
      miscompares++;
      $display("FAIL priority_frame_done: pulses=%0d next=%b, required pulses=1 next=1", fr_fd_cnt, fr_fd_next);
    end
  endtask

  task automatic test_blanking();
    logic [7:0] exp_on  [DIGITS] = '{8'hFF, 8'hFF, 8'hFF, 8'h90, 8'hC0, 8'hF8};
    logic [7:0] exp_off [DIGITS] = '{8'hFF, 8'hC0, 8'hC0, 8'h90, 8'hC0, 8'hF8};
    bdata = {1'b0, 20'h00907};
    blank_lz = 1'b1;
    capture_frame("blank_lz1");
    for (int p = 0; p < DIGITS; p++) begin
      vectors++;
      if (fr_seg[p] !== exp_on[p]) begin
        miscompares++;
        $display("FAIL blank_on_pos%0d: seg=%h, required %h", p, fr_seg[p], exp_on[p]);
      end
    end
    blank_lz = 1'b0;
    capture_frame("blank_lz0");
    for (int p = 0; p < DIGITS; p++) begin
      vectors++;
      if (fr_seg[p] !== exp_off[p]) begin
        miscompares++;
        $display("FAIL blank_off_pos%0d: seg=%h, required %h", p, fr_seg[p], exp_off[p]);
      end
    end
    bdata = '0;
  endtask

  task automatic test_hold();
    logic [7:0] exp [5] = '{8'hF9, 8'hF9, 8'hF9, 8'hFF, 8'hA4};
    logic [2:0] exp_sel [5] = '{3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    adata = {1'b0, 20'h11111};
    blank_lz = 1'b0;
    capture_frame("hold_pre");
    step(12);
    adata = {1'b0, 20'h22222};
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (sel !== exp_sel[k] || seg !== exp[k]) begin
        miscompares++;
        $display("FAIL hold_step%0d: sel=%0d seg=%h, required sel=%0d seg=%h", k, sel, seg, exp_sel[k], exp[k]);
      end
      step(4);
    end
    $display("hold: new value first seen at position 1 of next frame");
  endtask

  task automatic test_invalid();
    adata = {1'b0, 20'h0000A};
    dp = 6'b100000;
    blank_lz = 1'b0;
    capture_frame("invalid");
    vectors++;
    if (fr_seg[5] !== 8'h7F) begin
      miscompares++;
      $display("FAIL invalid_pos5: seg=%h, required 7f", fr_seg[5]);
    end
    vectors++;
    if (fr_seg[4] !== 8'hC0 || fr_seg[0] !== 8'hFF) begin
      miscompares++;
      $display("FAIL invalid_others: pos4=%h pos0=%h, required c0 ff", fr_seg[4], fr_seg[0]);
    end
    dp = '0;
  endtask

  task automatic test_midreset();
    adata = {1'b1, 20'h12345};
    capture_frame("midreset_pre");
    step(16);
    vectors++;
    if (sel !== 3'd4 || seg !== 8'h99) begin
      miscompares++;
      $display("FAIL midreset_setup: sel=%0d seg=%h, required sel=4 seg=99", sel, seg);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    vectors++;
    if (sel !== 3'd0 || seg !== 8'hFF || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_edge: sel=%0d seg=%h fd=%b, required sel=0 seg=ff fd=0", sel, seg, frame_done);
    end
    step(3);
    vectors++;
    if (sel !== 3'd0 || seg !== 8'hFF) begin
      miscompares++;
      $display("FAIL midreset_pos0: sel=%0d seg=%h, required sel=0 seg=ff", sel, seg);
    end
    step(1);
    vectors++;
    if (sel !== 3'd1 || seg !== 8'hC0) begin
      miscompares++;
      $display("FAIL midreset_cleared: sel=%0d seg=%h, required sel=1 seg=c0", sel, seg);
    end
    $display("midreset: resumed at sel=%0d seg=%h", sel, seg);
  endtask

  initial begin
    test_reset();
    test_priority();
    test_blanking();
    test_hold();
    test_invalid();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
